// File: rtl/ca_egr_snd_responder.sv
// Egress send responder: grants one request at a time against downstream
// buffer credit, then forwards exactly the granted data beats downstream.
module ca_egr_snd_responder #(
    parameter int unsigned BUF_BYTES = 65536,
    parameter int unsigned MAX_BURST = 4096
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic         req_tvalid,
    output logic         req_tready,
    input  logic [63:0]  req_tdata,
    output logic         resp_tvalid,
    input  logic         resp_tready,
    output logic [63:0]  resp_tdata,
    input  logic         data_tvalid,
    output logic         data_tready,
    input  logic [511:0] data_tdata,
    output logic         out_tvalid,
    input  logic         out_tready,
    output logic [511:0] out_tdata,
    output logic         out_tlast,
    output logic [8:0]   out_tuser,
    input  logic         credit_ret_valid,
    input  logic [16:0]  credit_ret_bytes,
    output logic [16:0]  credit_free,
    output logic [2:0]   err_status
);

    localparam logic [16:0] BUF_MAX = 17'(BUF_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_RESP,
        S_DATA
    } state_t;

    state_t       state_q, state_d;
    logic         init_q;
    logic [15:0]  len_q, len_d;
    logic         sof_q, sof_d;
    logic         eof_q, eof_d;
    logic [8:0]   ch_q, ch_d;
    logic [15:0]  grant_q, grant_d;
    logic [16:0]  need_q, need_d;
    logic [10:0]  beats_q, beats_d;
    logic [16:0]  credit_q, credit_d;
    logic [2:0]   err_q, err_d;
    logic         ov_q, ov_d;
    logic [511:0] od_q, od_d;
    logic         ol_q, ol_d;
    logic [8:0]   ou_q, ou_d;

    logic         req_hs, resp_hs, data_hs;
    logic         len_zero, len_big;
    logic [16:0]  need_c;
    logic [17:0]  credit_sum;

    assign req_hs   = req_tvalid && req_tready;
    assign resp_hs  = resp_tvalid && resp_tready;
    assign data_hs  = data_tvalid && data_tready;
    assign len_zero = (len_q == 16'd0);
    assign len_big  = 32'(len_q) > MAX_BURST;
    assign need_c   = ({1'b0, len_q} + 17'd63) & ~17'd63;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_hs) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (len_zero || len_big) state_d = S_RESP;
                else if (credit_q >= need_c) state_d = S_RESP;
                else state_d = S_WAIT;
            end
            S_WAIT: begin
                if (credit_q >= need_q) state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_hs) state_d = (grant_q != 16'd0) ? S_DATA : S_IDLE;
            end
            S_DATA: begin
                if (data_hs && beats_q == 11'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_tready  = (state_q == S_IDLE) && init_q;
        resp_tvalid = (state_q == S_RESP);
        resp_tdata  = 64'd0;
        if (resp_tvalid) begin
            resp_tdata = {grant_q, 14'd0, eof_q, sof_q, 23'd0, ch_q};
        end
        data_tready = (state_q == S_DATA) && (!ov_q || out_tready);
    end

    always_comb begin
        len_d   = len_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        ch_d    = ch_q;
        grant_d = grant_q;
        need_d  = need_q;
        beats_d = beats_q;
        err_d   = err_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        ou_d    = ou_q;

        if (req_hs) begin
            len_d = req_tdata[63:48];
            eof_d = req_tdata[33];
            sof_d = req_tdata[32];
            ch_d  = req_tdata[8:0];
        end

        // Invalid lengths are answered with a zero grant and no credit use
        if (state_q == S_CHECK) begin
            if (len_zero || len_big) begin
                grant_d = 16'd0;
                need_d  = 17'd0;
                err_d   = err_q | {1'b0, len_big, len_zero};
            end else begin
                grant_d = len_q;
                need_d  = need_c;
            end
        end

        if (resp_hs && grant_q != 16'd0) begin
            beats_d = need_q[16:6];
        end else if (data_hs) begin
            beats_d = beats_q - 11'd1;
        end

        if (data_hs) begin
            ov_d = 1'b1;
            od_d = data_tdata;
            ol_d = (beats_q == 11'd1);
            ou_d = ch_q;
        end else if (out_tready) begin
            ov_d = 1'b0;
        end

        credit_sum = {1'b0, credit_q}
                   - (resp_hs ? {1'b0, need_q} : 18'd0)
                   + (credit_ret_valid ? {1'b0, credit_ret_bytes} : 18'd0);
        if (credit_sum > {1'b0, BUF_MAX}) begin
            credit_d = BUF_MAX;
            err_d[2] = 1'b1;
        end else begin
            credit_d = credit_sum[16:0];
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            init_q   <= 1'b0;
            len_q    <= '0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            ch_q     <= '0;
            grant_q  <= '0;
            need_q   <= '0;
            beats_q  <= '0;
            credit_q <= BUF_MAX;
            err_q    <= '0;
            ov_q     <= 1'b0;
            od_q     <= '0;
            ol_q     <= 1'b0;
            ou_q     <= '0;
        end else begin
            init_q   <= 1'b1;
            len_q    <= len_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            ch_q     <= ch_d;
            grant_q  <= grant_d;
            need_q   <= need_d;
            beats_q  <= beats_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
            ol_q     <= ol_d;
            ou_q     <= ou_d;
        end
    end

    assign out_tvalid  = ov_q;
    assign out_tdata   = od_q;
    assign out_tlast   = ol_q;
    assign out_tuser   = ou_q;
    assign credit_free = credit_q;
    assign err_status  = err_q;

endmodule

// File: tb/tb_ca_egr_snd_responder.sv
// Bench for ca_egr_snd_responder: credit and beat-stream model with
// directed request sequences.
module tb_ca_egr_snd_responder;

    localparam int BUF = 65536;

    logic         ap_clk = 1'b0;
    logic         ap_rst;
    logic         req_tvalid, req_tready;
    logic [63:0]  req_tdata;
    logic         resp_tvalid, resp_tready;
    logic [63:0]  resp_tdata;
    logic         data_tvalid, data_tready;
    logic [511:0] data_tdata;
    logic         out_tvalid;
    logic         out_tready = 1'b1;
    logic [511:0] out_tdata;
    logic         out_tlast;
    logic [8:0]   out_tuser;
    logic         credit_ret_valid;
    logic [16:0]  credit_ret_bytes;
    logic [16:0]  credit_free;
    logic [2:0]   err_status;

    always #5 ap_clk = ~ap_clk;

    ca_egr_snd_responder #(.BUF_BYTES(BUF), .MAX_BURST(4096)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
        .resp_tvalid(resp_tvalid), .resp_tready(resp_tready), .resp_tdata(resp_tdata),
        .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tlast(out_tlast), .out_tuser(out_tuser),
        .credit_ret_valid(credit_ret_valid), .credit_ret_bytes(credit_ret_bytes),
        .credit_free(credit_free), .err_status(err_status)
    );

    typedef struct packed {
        logic [511:0] d;
        logic         last;
        logic [8:0]   u;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    bit          bp = 0;
    int          m_credit = BUF;
    int          m_left = 0;
    int          cur_need = 0;
    logic [8:0]  cur_ch = '0;
    logic [63:0] exp_resp = '0;
    logic [63:0] last_resp;
    beat_t       expq[$];
    int          out_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    always @(posedge ap_clk) begin
        #1;
        out_tready = bp ? ~out_tready : 1'b1;
    end

    // Reference model: credit ledger plus queue of beats owed downstream
    always @(negedge ap_clk) begin
        int    nc;
        beat_t b;
        if (ap_rst) begin
            m_credit = BUF;
            m_left   = 0;
            expq.delete();
        end else begin
            chk("credit_free", credit_free, m_credit);
            if (resp_tvalid) chk("resp_tdata", resp_tdata, exp_resp);
            if (out_tvalid && !out_tready) chk("data_tready_bp", data_tready, 0);
            if (m_left == 0) chk("data_tready_idle", data_tready, 0);
            if (out_tvalid && out_tready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got beat %0h with none owed", out_tdata[31:0]);
                end else begin
                    b = expq.pop_front();
                    if (out_tdata !== b.d || out_tlast !== b.last || out_tuser !== b.u) begin
                        errors++;
                        $display("FAIL out_beat: got %0h/%b/%0d expected %0h/%b/%0d",
                                 out_tdata[31:0], out_tlast, out_tuser,
                                 b.d[31:0], b.last, b.u);
                    end
                end
                out_cnt++;
            end
            if (data_tvalid && data_tready) begin
                b.d    = data_tdata;
                b.last = (m_left == 1);
                b.u    = cur_ch;
                expq.push_back(b);
                m_left--;
            end
            nc = m_credit;
            if (resp_tvalid && resp_tready) begin
                nc     = nc - cur_need;
                m_left = cur_need / 64;
            end
            if (credit_ret_valid) nc = nc + int'(credit_ret_bytes);
            if (nc > BUF) nc = BUF;
            m_credit = nc;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_tready"}, req_tready, 0);
        chk({tag, "_resp_tvalid"}, resp_tvalid, 0);
        chk({tag, "_resp_tdata"}, resp_tdata, 0);
        chk({tag, "_data_tready"}, data_tready, 0);
        chk({tag, "_out_tvalid"}, out_tvalid, 0);
        chk({tag, "_out_tdata"}, {63'd0, |out_tdata}, 0);
        chk({tag, "_out_tlast"}, out_tlast, 0);
        chk({tag, "_out_tuser"}, out_tuser, 0);
        chk({tag, "_err"}, err_status, 0);
        chk({tag, "_credit"}, credit_free, BUF);
    endtask

    task automatic send_req(input int len, input int ch, input bit sof, input bit eof);
        int g = 0;
        cur_ch    = 9'(ch);
        cur_need  = (len == 0 || len > 4096) ? 0 : ((len + 63) / 64) * 64;
        exp_resp  = {16'(cur_need == 0 ? 0 : len), 14'd0, eof, sof, 23'd0, 9'(ch)};
        req_tdata = {16'(len), 14'h2aaa, eof, sof, 23'h15a5a5, 9'(ch)};
        req_tvalid = 1'b1;
        while (g < 50) begin
            @(negedge ap_clk);
            if (req_tready) break;
            g++;
        end
        if (g >= 50) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: req_tready never seen high");
        end
        tick;
        req_tvalid = 1'b0;
    endtask

    // Request with credit available: response exactly two cycles later
    task automatic req_imm(input int len, input int ch, input bit sof, input bit eof);
        send_req(len, ch, sof, eof);
        @(negedge ap_clk);
        chk("resp_t1", resp_tvalid, 0);
        @(negedge ap_clk);
        chk("resp_t2", resp_tvalid, 1);
        last_resp = resp_tdata;
        tick;
    endtask

    task automatic send_beats(input int n, input int base);
        int k = 0;
        int g = 0;
        int c0 = out_cnt;
        data_tvalid = 1'b1;
        data_tdata  = {16{32'(base)}};
        while (k < n && g < 500) begin
            @(negedge ap_clk);
            if (data_tready) k++;
            g++;
            tick;
            data_tdata = {16{32'(base + k)}};
        end
        if (k < n) begin
            checks++;
            errors++;
            $display("FAIL data_timeout: accepted %0d expected %0d", k, n);
        end
        repeat (3) begin
            @(negedge ap_clk);
            chk("data_after_burst", data_tready, 0);
        end
        tick;
        data_tvalid = 1'b0;
        g = 0;
        while (expq.size() != 0 && g < 100) begin
            @(negedge ap_clk);
            #1;
            g++;
        end
        chk("beat_count", 64'(out_cnt - c0), 64'(n));
    endtask

    initial begin
        ap_rst           = 1'b1;
        req_tvalid       = 1'b0;
        req_tdata        = '0;
        resp_tready      = 1'b1;
        data_tvalid      = 1'b0;
        data_tdata       = '0;
        credit_ret_valid = 1'b0;
        credit_ret_bytes = '0;
        #3;
        check_reset_vals("rst");
        repeat (2) tick;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("req_tready_rel0", req_tready, 0);
        @(negedge ap_clk);
        chk("req_tready_rel1", req_tready, 1);
        tick;

        req_imm(256, 5, 1'b1, 1'b1);
        chk("resp_single", last_resp, 64'h0100_0003_0000_0005);
        send_beats(4, 32'h1000);
        chk("credit_single", credit_free, 65280);

        bp = 1;
        req_imm(512, 17, 1'b1, 1'b0);
        send_beats(8, 32'h2000);
        bp = 0;
        chk("credit_bp", credit_free, 64768);

        resp_tready = 1'b0;
        send_req(0, 3, 1'b1, 1'b1);
        @(negedge ap_clk);
        @(negedge ap_clk);
        chk("zero_resp_valid", resp_tvalid, 1);
        last_resp = resp_tdata;
        repeat (3) tick;
        resp_tready = 1'b1;
        @(negedge ap_clk);
        chk("zero_resp_held", resp_tvalid, 1);
        tick;
        chk("resp_zero", last_resp, 64'h0000_0003_0000_0003);
        data_tvalid = 1'b1;
        repeat (4) begin
            @(negedge ap_clk);
            chk("zero_no_data", data_tready, 0);
        end
        tick;
        data_tvalid = 1'b0;
        @(negedge ap_clk);
        chk("zero_err", err_status, 3'b001);
        chk("zero_idle", req_tready, 1);
        tick;

        req_imm(4097, 9, 1'b0, 1'b1);
        chk("resp_big", last_resp, 64'h0000_0002_0000_0009);
        @(negedge ap_clk);
        chk("big_err", err_status, 3'b011);
        chk("big_credit", credit_free, 64768);
        tick;

        credit_ret_valid = 1'b1;
        credit_ret_bytes = 17'd768;
        tick;
        credit_ret_bytes = 17'd64;
        tick;
        credit_ret_valid = 1'b0;
        @(negedge ap_clk);
        chk("ovf_credit", credit_free, 65536);
        chk("ovf_err", err_status, 3'b111);
        tick;

        req_imm(512, 7, 1'b1, 1'b1);
        data_tvalid = 1'b1;
        data_tdata  = {16{32'h3000}};
        repeat (3) tick;
        ap_rst      = 1'b1;
        data_tvalid = 1'b0;
        #1;
        check_reset_vals("mid");
        repeat (2) tick;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("req_tready_mid0", req_tready, 0);
        @(negedge ap_clk);
        chk("req_tready_mid1", req_tready, 1);
        tick;
        req_imm(128, 9, 1'b1, 1'b0);
        chk("resp_after_rst", last_resp, 64'h0080_0001_0000_0009);
        send_beats(2, 32'h4000);
        chk("credit_after_rst", credit_free, 65408);

        credit_ret_valid = 1'b1;
        credit_ret_bytes = 17'd128;
        tick;
        credit_ret_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req_imm(4096, i, 1'b1, 1'b1);
            send_beats(64, (i + 1) << 16);
        end
        chk("drained", credit_free, 0);
        send_req(256, 11, 1'b1, 1'b1);
        repeat (6) begin
            @(negedge ap_clk);
            chk("stall_resp", resp_tvalid, 0);
        end
        tick;
        credit_ret_valid = 1'b1;
        credit_ret_bytes = 17'd256;
        @(negedge ap_clk);
        chk("stall_c0", resp_tvalid, 0);
        tick;
        credit_ret_valid = 1'b0;
        @(negedge ap_clk);
        chk("stall_c1", resp_tvalid, 0);
        @(negedge ap_clk);
        chk("stall_c2", resp_tvalid, 1);
        tick;
        send_beats(4, 32'h5000);
        chk("credit_final", credit_free, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
